lif_neuron_array: RTL and testbench

- Time-multiplexed array of N_NEURONS leaky integrate-and-fire neurons sharing one datapath; per-neuron state (membrane potential, refractory count) is held in register arrays.
- Input current events arrive on a valid/ready stream and are integrated immediately. A global step pulse triggers a sweep that applies leak, threshold and refractory handling to every neuron in index order.
- Spikes leave as neuron-ID events on a valid/ready stream toward the downstream synapse/router logic.

---
 rtl/lif_neuron_array.sv | 177 +++++++++++++++++
 tb/tb_lif_neuron_array.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array.
// One datapath sweeps all neurons per step pulse.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   in_valid/in_ready   input current event handshake
//   in_id, in_current   target neuron and current to add
//   step                timestep pulse, starts a sweep
//   threshold           spike threshold
//   refractory_period   silent steps after a spike
//   out_valid/out_ready spike event handshake
//   out_id              spiking neuron index
//   sweep_done          pulse when a sweep finishes
//   step_overrun        sticky, a step was dropped
//   rd_id/rd_potential  registered debug read of potential
module lif_neuron_array #(
  parameter int N_NEURONS = 16,
  parameter int ID_W = $clog2(N_NEURONS),
  parameter int DATA_W = 16,
  parameter int REF_W = 8,
  parameter int LEAK_SHIFT = 4,
  parameter logic [DATA_W-1:0] V_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ID_W-1:0]   in_id,
  input  logic [DATA_W-1:0] in_current,
  input  logic              step,
  input  logic [DATA_W-1:0] threshold,
  input  logic [REF_W-1:0]  refractory_period,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic              sweep_done,
  output logic              step_overrun,
  input  logic [ID_W-1:0]   rd_id,
  output logic [DATA_W-1:0] rd_potential
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    EMIT
  } state_t;

  state_t            state_q;
  logic [ID_W-1:0]   idx_q;
  logic              pending_q;
  logic              out_valid_q;
  logic [ID_W-1:0]   out_id_q;
  logic              sweep_done_q;
  logic              overrun_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] v_q   [N_NEURONS];
  logic [REF_W-1:0]  ref_q [N_NEURONS];

  logic              in_hit;
  logic              accept;
  logic [DATA_W-1:0] in_v;
  logic [REF_W-1:0]  in_ref;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] sat;
  logic [DATA_W-1:0] cur_v;
  logic [REF_W-1:0]  cur_ref;
  logic [DATA_W-1:0] vl;
  logic              last;
  logic              spike_now;
  logic              adv;
  logic [DATA_W-1:0] rd_val;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign in_hit   = int'(in_id) < N_NEURONS;
  assign in_v     = in_hit ? v_q[in_id] : '0;
  assign in_ref   = in_hit ? ref_q[in_id] : '0;
  assign sum      = {1'b0, in_v} + {1'b0, in_current};
  assign sat      = sum[DATA_W] ? '1 : sum[DATA_W-1:0];

  assign cur_v   = v_q[idx_q];
  assign cur_ref = ref_q[idx_q];

  generate
    if (LEAK_SHIFT == 0) begin : g_full_leak
      assign vl = '0;
    end else begin : g_shift_leak
      assign vl = cur_v - (cur_v >> LEAK_SHIFT);
    end
  endgenerate

  assign last = (idx_q == ID_W'(N_NEURONS - 1));

  assign spike_now = (state_q == SWEEP)
                  && (cur_ref == '0)
                  && (vl >= threshold);

  // Neuron idx is finished: either processed without
  // a spike, or its spike has been handed off.
  assign adv = ((state_q == SWEEP) && !spike_now)
            || ((state_q == EMIT) && out_ready);

  assign rd_val = (int'(rd_id) < N_NEURONS) ? v_q[rd_id] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]   <= V_RESET;
        ref_q[i] <= '0;
      end
      state_q      <= IDLE;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_id_q     <= '0;
      sweep_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      rd_q         <= '0;
    end else begin
      sweep_done_q <= 1'b0;
      rd_q         <= rd_val;

      // Only one step may queue behind a running sweep.
      if (step && state_q != IDLE) begin
        if (pending_q) overrun_q <= 1'b1;
        else           pending_q <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (accept && in_hit && in_ref == '0)
            v_q[in_id] <= sat;
          if (step || pending_q) begin
            if (step && pending_q) overrun_q <= 1'b1;
            pending_q <= 1'b0;
            idx_q     <= '0;
            state_q   <= SWEEP;
          end
        end
        SWEEP: begin
          if (cur_ref != '0) begin
            ref_q[idx_q] <= cur_ref - REF_W'(1);
          end else if (spike_now) begin
            v_q[idx_q]   <= V_RESET;
            ref_q[idx_q] <= refractory_period;
            out_valid_q  <= 1'b1;
            out_id_q     <= idx_q;
            state_q      <= EMIT;
          end else begin
            v_q[idx_q] <= vl;
          end
        end
        EMIT: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase

      if (adv) begin
        if (last) begin
          sweep_done_q <= 1'b1;
          state_q      <= IDLE;
        end else begin
          idx_q   <= idx_q + ID_W'(1);
          state_q <= SWEEP;
        end
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_id       = out_id_q;
  assign sweep_done   = sweep_done_q;
  assign step_overrun = overrun_q;
  assign rd_potential = rd_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Testbench for lif_neuron_array.
// Vector table plus spike scoreboard.
module tb_lif_neuron_array;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_id;
  logic [15:0] in_current;
  logic        step;
  logic [15:0] threshold;
  logic [7:0]  refractory_period;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_id;
  logic        sweep_done;
  logic        step_overrun;
  logic [3:0]  rd_id;
  logic [15:0] rd_potential;

  int checks = 0;
  int fails  = 0;
  int sb[$];

  typedef struct {
    int inj;
    int id;
    int cur;
    int stp;
    int exp_v;
    int spk;
  } vec_t;

  vec_t tbl[10];

  lif_neuron_array dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_id             (in_id),
    .in_current        (in_current),
    .step              (step),
    .threshold         (threshold),
    .refractory_period (refractory_period),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_id            (out_id),
    .sweep_done        (sweep_done),
    .step_overrun      (step_overrun),
    .rd_id             (rd_id),
    .rd_potential      (rd_potential)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // One clock: observe spike handshakes on the falling
  // edge, then step past the rising edge.
  task automatic cyc();
    int e;
    @(negedge clk);
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL spike_unexpected got=%0d exp=none",
                 out_id);
      end else begin
        e = sb.pop_front();
        chk("spike_id", int'(out_id), e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(int lim, string nm);
    bit found = 0;
    for (int i = 0; i < lim; i++) begin
      if (sweep_done) begin
        found = 1;
        break;
      end
      cyc();
    end
    chk(nm, int'(found), 1);
  endtask

  initial begin
    tbl[0] = '{1, 3,   800, 1, 750, 0};
    tbl[1] = '{1, 3,   300, 1, 985, 0};
    tbl[2] = '{1, 3,   100, 1,   0, 1};
    tbl[3] = '{1, 3,   500, 1,   0, 0};
    tbl[4] = '{0, 3,     0, 1,   0, 0};
    tbl[5] = '{1, 3,  1200, 1,   0, 1};
    tbl[6] = '{0, 3,     0, 1,   0, 0};
    tbl[7] = '{0, 3,     0, 1,   0, 0};
    tbl[8] = '{1, 0, 'hFFF0, 0, 'hFFF0, 0};
    tbl[9] = '{1, 0, 'h0100, 0, 'hFFFF, 0};

    reset             = 1'b1;
    in_valid          = 1'b0;
    in_id             = '0;
    in_current        = '0;
    step              = 1'b0;
    threshold         = 16'd1000;
    refractory_period = 8'd2;
    out_ready         = 1'b1;
    rd_id             = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_overrun", int'(step_overrun), 0);
    chk("rst_done", int'(sweep_done), 0);
    chk("rst_out_id", int'(out_id), 0);
    chk("rst_rd", int'(rd_potential), 0);
    for (int i = 0; i < 16; i++) begin
      rd_id = 4'(i);
      cyc();
      chk($sformatf("rst_v%0d", i), int'(rd_potential), 0);
    end

    // Leak, threshold, refractory, saturation rows.
    for (int k = 0; k < 10; k++) begin
      if (tbl[k].spk != 0) sb.push_back(tbl[k].id);
      in_valid   = (tbl[k].inj != 0);
      in_id      = 4'(tbl[k].id);
      in_current = 16'(tbl[k].cur);
      step       = (tbl[k].stp != 0);
      cyc();
      in_valid = 1'b0;
      step     = 1'b0;
      if (tbl[k].stp != 0)
        wait_done(100, $sformatf("row%0d_done", k));
      rd_id = 4'(tbl[k].id);
      cyc();
      chk($sformatf("row%0d_v", k), int'(rd_potential),
          tbl[k].exp_v);
    end
    chk("rows_sb_empty", sb.size(), 0);

    // Backpressure: every neuron fires, stall on id 0.
    threshold         = 16'd0;
    refractory_period = 8'd0;
    out_ready         = 1'b0;
    for (int i = 0; i < 16; i++) sb.push_back(i);
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_id", int'(out_id), 0);
      chk("bp_in_ready", int'(in_ready), 0);
      cyc();
    end
    out_ready = 1'b1;
    wait_done(200, "bp_done");
    chk("bp_sb_empty", sb.size(), 0);

    // Step during a sweep queues a second sweep.
    cyc();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 16; i++) sb.push_back(i);
    step = 1'b1;
    cyc();
    step = 1'b0;
    repeat (3) cyc();
    step = 1'b1;
    cyc();
    step = 1'b0;
    wait_done(200, "pend_done1");
    cyc();
    wait_done(200, "pend_done2");
    chk("pend_overrun", int'(step_overrun), 0);
    chk("pend_sb_empty", sb.size(), 0);

    // Two extra steps during a sweep overrun.
    cyc();
    for (int i = 0; i < 16; i++) sb.push_back(i);
    step = 1'b1;
    cyc();
    step = 1'b0;
    repeat (2) cyc();
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("ovr_flag", int'(step_overrun), 1);
    wait_done(200, "ovr_done");

    // Idle gap before the queued sweep still
    // accepts input; then stall in EMIT and reset.
    in_valid   = 1'b1;
    in_id      = 4'd5;
    in_current = 16'h1234;
    out_ready  = 1'b0;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("emit_valid", int'(out_valid), 1);
    chk("emit_id", int'(out_id), 0);
    rd_id = 4'd5;
    cyc();
    chk("emit_v5", int'(rd_potential), 'h1234);
    chk("ovr_sticky", int'(step_overrun), 1);
    reset = 1'b1;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    repeat (2) cyc();
    reset = 1'b0;
    repeat (2) cyc();
    chk("post_rst_v5", int'(rd_potential), 0);
    chk("post_rst_overrun", int'(step_overrun), 0);
    chk("post_rst_valid", int'(out_valid), 0);
    chk("post_rst_done", int'(sweep_done), 0);
    sb.delete();
    out_ready = 1'b1;
    chk("post_rst_sb", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
